dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int DATA_W      = 64;
    localparam int DWORD_BYTES = 8;
    localparam int DWORD_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake between the core load/store port and the data-memory responder.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_address;
    logic [DATA_W-1:0] req_write_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_read_data;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_address, req_write_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_read_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_write_data, rsp_ready,
        output req_ready, rsp_valid, rsp_read_data, rsp_error
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x WIDTH storage with synchronous write and registered read; contents survive reset.
module dmem_array #(
    parameter  int DEPTH = 128,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Read register only loads on re so the response data stays put while the core stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed LATENCY, range check.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects addresses that are not doubleword aligned.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(LATENCY) + 1;
    localparam int WORD_AW = DATA_W - DWORD_SHIFT;
    localparam logic [CW-1:0]      COUNT_INIT = CW'(LATENCY - 1);
    localparam logic [WORD_AW-1:0] DEPTH_W    = WORD_AW'(DEPTH);

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic              ready_reg;
    logic              valid_reg;
    logic              error_reg;
    logic              load_ok_reg;
    logic              write_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              out_of_range;
    logic              misaligned;
    logic              access_err;
    logic              do_access;
    logic              mem_we;
    logic              mem_re;
    logic [AW-1:0]     index;
    logic [DATA_W-1:0] mem_rdata;

    assign index        = addr_reg[DWORD_SHIFT +: AW];
    assign out_of_range = (addr_reg[DATA_W-1:DWORD_SHIFT] >= DEPTH_W);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = |addr_reg[DWORD_SHIFT-1:0];
`else
    // Byte offset is deliberately dropped: misaligned accesses hit the truncated doubleword.
    logic unused_low_bits;
    assign unused_low_bits = ^addr_reg[DWORD_SHIFT-1:0];
    assign misaligned      = 1'b0;
`endif

    assign access_err = out_of_range | misaligned;
    assign do_access  = (state_reg == WAIT) && (count_reg == '0);
    assign mem_we     = do_access & write_reg & ~access_err;
    assign mem_re     = do_access & ~write_reg & ~access_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (index),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
            error_reg   <= 1'b0;
            load_ok_reg <= 1'b0;
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_reg <= bus.req_write;
                        addr_reg  <= bus.req_address;
                        wdata_reg <= bus.req_write_data;
                        count_reg <= COUNT_INIT;
                        ready_reg <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (count_reg == '0) begin
                        valid_reg   <= 1'b1;
                        error_reg   <= access_err;
                        load_ok_reg <= ~write_reg & ~access_err;
                        state_reg   <= RESP;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_reg   <= 1'b0;
                        error_reg   <= 1'b0;
                        load_ok_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    valid_reg   <= 1'b0;
                    error_reg   <= 1'b0;
                    load_ok_reg <= 1'b0;
                    ready_reg   <= 1'b1;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    // Array output is unreset, so a registered qualifier forces zero for stores, errors and reset.
    assign bus.rsp_read_data = load_ok_reg ? mem_rdata : '0;
    assign bus.req_ready     = ready_reg;
    assign bus.rsp_valid     = valid_reg;
    assign bus.rsp_error     = error_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=128, LATENCY=2) with a response scoreboard.
module tb_dmem_responder;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [63:0] model [DEPTH];

    dmem_if bus ();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction: issue, wait for response, check against scoreboard, optionally stall.
    task automatic txn(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_data, input bit exp_err, input int stall,
                       input string name);
        exp_t e;
        int   cyc;
        bit   got;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);

        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready_before: got %b want 1", name, bus.req_ready);
        end
        bus.req_write      = wr;
        bus.req_address    = addr;
        bus.req_write_data = wdata;
        bus.req_valid      = 1'b1;
        @(posedge clk); #1;
        bus.req_valid      = 1'b0;
        bus.req_write      = ~wr;
        bus.req_address    = ~addr;
        bus.req_write_data = ~wdata;

        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s req_ready_busy: got %b want 0", name, bus.req_ready);
        end

        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!got) begin
                @(posedge clk); #1;
                if (bus.rsp_valid === 1'b1) begin
                    got = 1'b1;
                    cyc = i;
                end
            end
        end
        n_checks++;
        if (!got || cyc != LATENCY) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (valid=%b) want %0d", name, cyc, got, LATENCY);
        end

        e = sb.pop_front();
        n_checks++;
        if (bus.rsp_read_data !== e.data) begin
            n_fail++;
            $display("FAIL %s rsp_read_data: got %h want %h", name, bus.rsp_read_data, e.data);
        end
        n_checks++;
        if (bus.rsp_error !== e.err) begin
            n_fail++;
            $display("FAIL %s rsp_error: got %b want %b", name, bus.rsp_error, e.err);
        end

        // While stalled, hammer with a store to 0x0 that must be ignored.
        for (int s = 0; s < stall; s++) begin
            bus.req_valid      = 1'b1;
            bus.req_write      = 1'b1;
            bus.req_address    = 64'h0;
            bus.req_write_data = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge clk); #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.rsp_read_data !== e.data || bus.rsp_error !== e.err) begin
                n_fail++;
                $display("FAIL %s stall%0d: got valid=%b ready=%b data=%h err=%b want 1 0 %h %b",
                         name, s, bus.rsp_valid, bus.req_ready, bus.rsp_read_data,
                         bus.rsp_error, e.data, e.err);
            end
        end
        bus.req_valid = 1'b0;

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got ready=%b valid=%b want 1 0", name, bus.req_ready, bus.rsp_valid);
        end
        $display("txn %-14s wr=%0d addr=%h wdata=%h exp_data=%h exp_err=%0d", name, wr, addr, wdata,
                 exp_data, exp_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_address = '0;
        bus.req_write_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_read_data !== 64'h0 || bus.rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_read_data, bus.rsp_error);
        end
    endtask

    task automatic test_store_load();
        txn(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 0, "store_40");
        txn(1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "load_40");
        txn(1'b1, 64'h3F8, 64'hA5A5_0000_5A5A_FFFF, 64'h0, 1'b0, 0, "store_last");
        txn(1'b0, 64'h3F8, 64'h0, 64'hA5A5_0000_5A5A_FFFF, 1'b0, 0, "load_last");
    endtask

    task automatic test_out_of_range();
        txn(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0, "store_0");
        txn(1'b0, 64'h400, 64'h0, 64'h0, 1'b1, 0, "load_400");
        txn(1'b1, 64'h400, 64'h1111_2222_3333_4444, 64'h0, 1'b1, 0, "store_400");
        txn(1'b1, 64'h8000_0000_0000_0000, 64'h5555, 64'h0, 1'b1, 0, "store_high");
        txn(1'b0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "readback_0");
    endtask

    task automatic test_backpressure();
        txn(1'b0, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5, "stall_load_40");
        txn(1'b0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "ignored_check");
    endtask

    task automatic test_alignment();
        if (ALIGN_CHECK)
            txn(1'b0, 64'h44, 64'h0, 64'h0, 1'b1, 0, "load_44");
        else
            txn(1'b0, 64'h44, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, "load_44");
    endtask

    task automatic test_reset_in_wait();
        txn(1'b1, 64'h80, 64'h0000_0000_0000_1111, 64'h0, 1'b0, 0, "store_80_old");
        bus.req_write      = 1'b1;
        bus.req_address    = 64'h80;
        bus.req_write_data = 64'h1234;
        bus.req_valid      = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_read_data !== 64'h0 || bus.rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_read_data, bus.rsp_error);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        $display("txn %-14s aborted store 0x1234 to 0x80 by reset", "abort_80");
        txn(1'b0, 64'h80, 64'h0, 64'h0000_0000_0000_1111, 1'b0, 0, "load_80_old");
    endtask

    task automatic test_back_to_back();
        int idx;
        for (int i = 0; i < 8; i++) begin
            idx = 32 + i * 5;
            model[idx] = {$urandom, $urandom};
            txn(1'b1, 64'(idx * 8), model[idx], 64'h0, 1'b0, 0, "b2b_store");
        end
        for (int i = 7; i >= 0; i--) begin
            idx = 32 + i * 5;
            txn(1'b0, 64'(idx * 8), 64'h0, model[idx], 1'b0, 0, "b2b_load");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_alignment();
        test_reset_in_wait();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
